alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter that shares one combinational `alu` instance between `NUM_REQ` requesters, for example the execute stage and the address-generation path. Each requester presents operands and an `alu_op_e` over a valid/ready handshake. The arbiter drives the granted operands onto the ALU, captures `result_out`/`flags_out` into a single response register, and returns them to the owning requester over a second valid/ready handshake. The ALU itself sits outside this block; the arbiter connects to its ports.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..8.
- `DATA_W`, default 32: operand/result width; must match the ALU.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `clk_i` input 1: single clock; all state updates on rising edge.
- `reset_i` input 1: synchronous, active-low reset.
- `req_valid_i` input `NUM_REQ`: per-requester request valid.
- `req_ready_o` output `NUM_REQ`: per-requester request accepted this cycle.
- `req_a_i` input `NUM_REQ`×`DATA_W`: operand A per requester (packed array).
- `req_b_i` input `NUM_REQ`×`DATA_W`: operand B per requester.
- `req_op_i` input `NUM_REQ`×`alu_op_e`: operation per requester.
- `resp_valid_o` output `NUM_REQ`: one-hot; response available for that requester.
- `resp_ready_i` input `NUM_REQ`: requester consumes response.
- `resp_result_o` output `DATA_W`: registered ALU result, shared by all requesters.
- `resp_flags_o` output `alu_flags_t`: registered ALU flags.
- `alu_a_o`, `alu_b_o` output `DATA_W`: to ALU `a_in`/`b_in`.
- `alu_op_o` output `alu_op_e`: to ALU `op_in`.
- `alu_result_i` input `DATA_W`: from ALU `result_out`.
- `alu_flags_i` input `alu_flags_t`: from ALU `flags_out`.

## Operation
- **Response register states.** The response register has two states, EMPTY and FULL, with owner index `owner_q`. It is FULL exactly when one bit of `resp_valid_o` is set.
- **Grant condition (`can_issue`).** `can_issue` is true when the register is EMPTY, or FULL with `resp_ready_i[owner_q]` high (drain and refill in the same cycle).
- **Arbitration.** Arbitration is combinational round-robin over `req_valid_i`. The search starts at `prio_q` and wraps modulo `NUM_REQ`. The first valid index is the winner `gnt`.
- **Request ready.** `req_ready_o[gnt]` is 1 only when `can_issue` is true. All other `req_ready_o` bits are 0. At most one bit of `req_ready_o` is set per cycle.
- **ALU drive.** `alu_a_o`, `alu_b_o` and `alu_op_o` combinationally mux requester `gnt`.
  - When there is no winner, or `can_issue` is false, they drive 0, 0 and `ALU_OP_ADD`. This quiet default keeps the ALU inputs free of X.
- **Accept (`req_valid_i[gnt] & req_ready_o[gnt]`) at edge k:**
  - `resp_result_o` and `resp_flags_o` capture the ALU outputs.
  - `owner_q` becomes `gnt`, and the register becomes FULL.
  - `prio_q` becomes `(gnt+1) mod NUM_REQ`.
- **Drain only.** With FULL, `resp_ready_i[owner_q]` high and no accept, the register goes EMPTY. `resp_result_o` and `resp_flags_o` hold their last values.
- **Requester obligations.** A requester holds operands and op stable while valid and not ready. A requester may withdraw valid before it is accepted. `resp_ready_i` bits for non-owners are ignored.
- **`prio_q` stability.** `prio_q` changes only on an accept.
- **Reset (`reset_i` low at an edge):**
  - `resp_valid_o` goes to 0, the register to EMPTY, and `prio_q` and `owner_q` to 0.
  - `resp_result_o` goes to 0 and `resp_flags_o` to all-zero.
  - A response in flight is dropped.
  - `req_ready_o` is forced to 0 while `reset_i` is low.

## Timing
- **Latency.** Request accepted at edge k produces `resp_valid_o[owner]=1` in cycle k+1. This is one-cycle latency through a combinational ALU.
- **Throughput.** Back-to-back accepts, one per cycle, are sustained while each owner asserts `resp_ready_i` in the cycle its response is valid.
- **Backpressure.** An owner holding `resp_ready_i` low blocks all requesters. `req_ready_o` stays 0 until the owner drains.
- **Timing path.** `req_ready_o` depends combinationally on `req_valid_i`, `resp_ready_i` and state. There is no combinational path from `resp_ready_i` to the ALU outputs other than through `can_issue`.
- **Fairness.** With all requesters continuously valid and no backpressure, grants rotate 0,1,…,`NUM_REQ`-1,0. No requester waits more than `NUM_REQ`-1 accepts.

## Test plan
- **Reset values.** Hold `reset_i` low 3 cycles with all requests valid -> `req_ready_o`=0, `resp_valid_o`=0 and `resp_result_o`=0 throughout. First grant after release goes to requester 0.
- **Single add.** Requester 0 sends ADD with a=1200, b=5 -> accepted that cycle. Next cycle `resp_valid_o`=01 and `resp_result_o`=1205. Drain with `resp_ready_i[0]` -> `resp_valid_o`=00.
- **Round-robin.** Both requesters continuously valid; requester 0 issues SUB with a=10, b=3 and requester 1 issues ADD with a=7, b=8. Responses always ready -> owners alternate 0,1,0,1 and results alternate 7,15 on consecutive cycles.
- **Backpressure.** Requester 1 holds `resp_ready_i[1]` low for 4 cycles after its response -> `req_ready_o`=00 for those cycles and `resp_result_o` is stable. In the cycle `resp_ready_i[1]` rises, requester 0 is accepted and a new response appears the next cycle.
- **Flags and wrap.** SUB with a=0, b=1 -> `resp_result_o`=32'hFFFF_FFFF and `resp_flags_o` equals the ALU flags for that op, captured once and held until drain.
- **Reset mid-operation.** With FULL and owner=1, pull `reset_i` low one cycle -> next cycle `resp_valid_o`=0 and `prio_q`=0. Requester 1 re-requests and receives a fresh result.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter (with alu_pkg)
// Purpose  : Round-robin sharing of one combinational ALU between requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_SUB = 3'd1,
    ALU_OP_AND = 3'd2,
    ALU_OP_OR  = 3'd3,
    ALU_OP_XOR = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]        req_a_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]        req_b_i,
  input  alu_pkg::alu_op_e [NUM_REQ-1:0]        req_op_i,
  output logic [NUM_REQ-1:0]                    resp_valid_o,
  input  logic [NUM_REQ-1:0]                    resp_ready_i,
  output logic [DATA_W-1:0]                     resp_result_o,
  output alu_pkg::alu_flags_t                   resp_flags_o,
  output logic [DATA_W-1:0]                     alu_a_o,
  output logic [DATA_W-1:0]                     alu_b_o,
  output alu_pkg::alu_op_e                      alu_op_o,
  input  logic [DATA_W-1:0]                     alu_result_i,
  input  alu_pkg::alu_flags_t                   alu_flags_i
);

  localparam int                 c_idx_w = ID_W + 1;
  localparam logic [NUM_REQ-1:0] c_one   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              r_state;
  logic [ID_W-1:0]     r_prio;
  logic [ID_W-1:0]     r_owner;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [DATA_W-1:0]   r_result;
  alu_pkg::alu_flags_t r_flags;

  logic [c_idx_w-1:0]  w_idx;
  logic [ID_W-1:0]     w_gnt;
  logic                w_found;
  logic                w_can_issue;
  logic                w_accept;

  // Search starts at r_prio and wraps; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_prio} + c_idx_w'(i);
      if (w_idx >= c_idx_w'(NUM_REQ)) begin
        w_idx = w_idx - c_idx_w'(NUM_REQ);
      end
      if (!w_found && req_valid_i[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_can_issue = (r_state == ST_EMPTY) || resp_ready_i[r_owner];
  assign w_accept    = reset_i && w_found && w_can_issue;
  assign req_ready_o = w_accept ? (c_one << w_gnt) : '0;

  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = alu_pkg::ALU_OP_ADD;
    if (w_found && w_can_issue) begin
      alu_a_o  = req_a_i[w_gnt];
      alu_b_o  = req_b_i[w_gnt];
      alu_op_o = req_op_i[w_gnt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state      <= ST_EMPTY;
      r_prio       <= '0;
      r_owner      <= '0;
      r_resp_valid <= '0;
      r_result     <= '0;
      r_flags      <= '0;
    end else if (w_accept) begin
      r_state      <= ST_FULL;
      r_owner      <= w_gnt;
      r_resp_valid <= c_one << w_gnt;
      r_result     <= alu_result_i;
      r_flags      <= alu_flags_i;
      r_prio       <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
    end else if ((r_state == ST_FULL) && resp_ready_i[r_owner]) begin
      // Drain only: result and flags keep their last values.
      r_state      <= ST_EMPTY;
      r_resp_valid <= '0;
    end
  end

  assign resp_valid_o  = r_resp_valid;
  assign resp_result_o = r_result;
  assign resp_flags_o  = r_flags;

endmodule

`default_nettype wire
